rv_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I datapath. It sequences fetch, decode, execute, memory and write-back for each instruction, and drives every datapath select and enable. It handshakes with the shared instruction/data memory port, samples the branch comparator flags, counts retired instructions, and traps on illegal opcodes or a memory timeout.

---
 rtl/rv_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB, drives
// datapath selects, handshakes with the shared memory port and traps on faults.
module rv_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             BrEq,
  input  logic             BrLT,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRW,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSel,
  output logic [2:0]       ImmSel,
  output logic             BrUn,
  output logic             ASel,
  output logic             BSel,
  output logic [3:0]       ALUSel,
  output logic             RegWEn,
  output logic [1:0]       WBSel,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  // Memory handshake: mem_req is a request held high until the cycle in which
  // mem_ready is sampled high; that cycle completes the transfer. mem_ready
  // seen while mem_req is low carries no meaning and is ignored.

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt_bit;
  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic       is_legal;
  logic       br_taken;
  logic [2:0] dec_imm;
  logic       dec_brun, dec_asel, dec_bsel;
  logic [3:0] dec_alu;
  logic       unused_instr_bits;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign alt_bit = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  // funct3 ALU mapping shared by R-type and I-type; SUB exists only for R-type.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec_imm  = IMM_I;
    dec_brun = 1'b0;
    dec_asel = 1'b0;
    dec_bsel = 1'b0;
    dec_alu  = ALU_ADD;
    case (opcode)
      OP_R:      dec_alu = arith_op(funct3, alt_bit, 1'b1);
      OP_I: begin
        dec_bsel = 1'b1;
        dec_alu  = arith_op(funct3, alt_bit, 1'b0);
      end
      OP_LOAD:   dec_bsel = 1'b1;
      OP_STORE: begin
        dec_bsel = 1'b1;
        dec_imm  = IMM_S;
      end
      OP_BRANCH: begin
        dec_asel = 1'b1;
        dec_bsel = 1'b1;
        dec_imm  = IMM_B;
        dec_brun = funct3[1];
      end
      OP_JAL: begin
        dec_asel = 1'b1;
        dec_bsel = 1'b1;
        dec_imm  = IMM_J;
      end
      OP_JALR:   dec_bsel = 1'b1;
      OP_LUI: begin
        dec_bsel = 1'b1;
        dec_imm  = IMM_U;
        dec_alu  = ALU_PASS_B;
      end
      OP_AUIPC: begin
        dec_asel = 1'b1;
        dec_bsel = 1'b1;
        dec_imm  = IMM_U;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      3'd0:         br_taken = BrEq;
      3'd1:         br_taken = ~BrEq;
      3'd4, 3'd6:   br_taken = BrLT;
      3'd5, 3'd7:   br_taken = ~BrLT;
      default:      br_taken = 1'b0;
    endcase
  end

  // Next state; the wait counter is zero whenever not stalled in FETCH/MEM.
  always_comb begin
    logic retire;
    state_d    = state_q;
    wait_cnt_d = '0;
    trap_d     = trap_q;
    cause_d    = cause_q;
    instret_d  = instret_q;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          retire  = is_store;
          state_d = is_store ? S_FETCH : S_WB;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      instret_q  <= instret_d;
    end
  end

  // Gating on rst_n makes a mid-instruction reset silence every enable at once.
  always_comb begin
    mem_req = 1'b0;
    MemRW   = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    PCSel   = 1'b0;
    ImmSel  = IMM_I;
    BrUn    = 1'b0;
    ASel    = 1'b0;
    BSel    = 1'b0;
    ALUSel  = ALU_ADD;
    RegWEn  = 1'b0;
    WBSel   = 2'd0;
    if (rst_n) begin
      if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) begin
        ImmSel = dec_imm;
        BrUn   = dec_brun;
        ASel   = dec_asel;
        BSel   = dec_bsel;
        ALUSel = dec_alu;
      end
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ready;
        end
        S_EXECUTE: begin
          if (is_branch) begin
            PCWrite = 1'b1;
            PCSel   = br_taken;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          MemRW   = is_store;
          PCWrite = is_store & mem_ready;
        end
        S_WB: begin
          RegWEn  = 1'b1;
          PCWrite = 1'b1;
          if (is_load) begin
            WBSel = 2'd0;
          end else if (is_jal || is_jalr) begin
            WBSel = 2'd2;
            PCSel = 1'b1;
          end else begin
            WBSel = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: per-cycle expected output vectors from an
// instruction-level reference model, compared by an independent monitor.
module tb_rv_multicycle_ctrl;
  localparam int TO    = 6;
  localparam int CNT_W = 32;
  localparam int OBS_W = 56;
  localparam logic [OBS_W-1:0] CTL_MASK = {8'h00, 10'h3FF, 38'h0};

  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4,
                 C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  logic             clk, rst_n;
  logic [31:0]      instr;
  logic             BrEq, BrLT, mem_ready;
  logic             mem_req, MemRW, IRWrite, PCWrite, PCSel, BrUn, ASel, BSel, RegWEn, trap;
  logic [2:0]       ImmSel, state;
  logic [3:0]       ALUSel;
  logic [1:0]       WBSel, trap_cause;
  logic [CNT_W-1:0] instret;

  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .BrEq(BrEq), .BrLT(BrLT),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemRW(MemRW), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSel(PCSel), .ImmSel(ImmSel), .BrUn(BrUn), .ASel(ASel),
    .BSel(BSel), .ALUSel(ALUSel), .RegWEn(RegWEn), .WBSel(WBSel), .state(state),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [OBS_W-1:0] exp_q[$];
  logic [CNT_W-1:0] model_ret;
  string            tname;

  // reference model
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  // {ImmSel[2:0], BrUn, ASel, BSel, ALUSel[3:0]}
  function automatic logic [9:0] ctl_of(input logic [31:0] ins);
    int         alu_tab[8];
    int         f3, alu, imm;
    logic       brun, a, b;
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = int'(ins[14:12]);
    alu = 0; imm = 0; brun = 0; a = 0; b = 0;
    case (cls_of(ins[6:0]))
      C_R: begin
        alu = alu_tab[f3];
        if (ins[30] && f3 == 0) alu = 1;
        if (ins[30] && f3 == 5) alu = 7;
      end
      C_I: begin
        b = 1; alu = alu_tab[f3];
        if (ins[30] && f3 == 5) alu = 7;
      end
      C_LOAD:  b = 1;
      C_STORE: begin b = 1; imm = 1; end
      C_BR:    begin a = 1; b = 1; imm = 2; brun = (f3 == 6 || f3 == 7); end
      C_JAL:   begin a = 1; b = 1; imm = 4; end
      C_JALR:  b = 1;
      C_LUI:   begin b = 1; imm = 3; alu = 10; end
      C_AUIPC: begin a = 1; b = 1; imm = 3; end
      default: ;
    endcase
    return {3'(imm), brun, a, b, 4'(alu)};
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      default:    return !lt;
    endcase
  endfunction

  function automatic logic [OBS_W-1:0] mk(input logic [2:0] st, input logic mreq,
      input logic mrw, input logic irw, input logic pcw, input logic pcs,
      input logic [9:0] ctl, input logic rwe, input logic [1:0] wbs,
      input logic trp, input logic [1:0] cause);
    return {st, mreq, mrw, irw, pcw, pcs, ctl, rwe, wbs, trp, cause, model_ret};
  endfunction

  function automatic logic [31:0] rand_instr(input int cls);
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  top, op;
    int          ld_tab[5], st_tab[3], br_tab[6];
    ld_tab = '{0, 1, 2, 4, 5};
    st_tab = '{0, 1, 2};
    br_tab = '{0, 1, 4, 5, 6, 7};
    r = $urandom();
    case (cls)
      C_R: begin
        f3 = 3'($urandom_range(0, 7));
        top = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {top, r[24:15], f3, r[11:7], 7'b0110011};
      end
      C_I: begin
        f3 = 3'($urandom_range(0, 7));
        top = (f3 == 1) ? 7'h00 : (f3 == 5) ? ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00) : r[31:25];
        return {top, r[24:15], f3, r[11:7], 7'b0010011};
      end
      C_LOAD:  return {r[31:15], 3'(ld_tab[$urandom_range(0, 4)]), r[11:7], 7'b0000011};
      C_STORE: return {r[31:15], 3'(st_tab[$urandom_range(0, 2)]), r[11:7], 7'b0100011};
      C_BR:    return {r[31:15], 3'(br_tab[$urandom_range(0, 5)]), r[11:7], 7'b1100011};
      C_JAL:   return {r[31:7], 7'b1101111};
      C_JALR:  return {r[31:15], 3'd0, r[11:7], 7'b1100111};
      C_LUI:   return {r[31:7], 7'b0110111};
      C_AUIPC: return {r[31:7], 7'b0010111};
      default: begin
        op = 7'h7F;
        while (cls_of(op) != C_ILL) op = 7'($urandom_range(0, 127));
        return {r[31:7], op};
      end
    endcase
  endfunction

  // driver tasks: called at posedge+1, push the expectation for this cycle
  task automatic step(input logic rdy, input logic eq, input logic lt, input logic [OBS_W-1:0] e);
    mem_ready = rdy;
    BrEq = eq;
    BrLT = lt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_ret = '0;
    repeat (n) step(rb(), rb(), rb(), mk(3'd0, 0, 0, 0, 0, 0, 10'd0, 0, 2'd0, 0, 2'd0));
    rst_n = 1'b1;
  endtask

  task automatic trap_then_reset(input logic [1:0] cause);
    repeat (3) step(rb(), rb(), rb(), mk(3'd5, 0, 0, 0, 0, 0, 10'd0, 0, 2'd0, 1, cause));
    do_reset(2);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic eq, input logic lt, input bit abort_mem);
    int         cls;
    logic [9:0] ctl;
    logic       st, tk;
    cls = cls_of(ins[6:0]);
    ctl = ctl_of(ins);
    st  = (cls == C_STORE);
    instr = ins;
    for (int w = 0; w < fw && w < TO; w++)
      step(1'b0, rb(), rb(), mk(3'd0, 1, 0, 0, 0, 0, 10'd0, 0, 2'd0, 0, 2'd0));
    if (fw >= TO) begin trap_then_reset(2'd2); return; end
    step(1'b1, rb(), rb(), mk(3'd0, 1, 0, 1, 0, 0, 10'd0, 0, 2'd0, 0, 2'd0));
    step(rb(), rb(), rb(), mk(3'd1, 0, 0, 0, 0, 0, 10'd0, 0, 2'd0, 0, 2'd0));
    if (cls == C_ILL) begin trap_then_reset(2'd1); return; end
    if (cls == C_BR) begin
      tk = taken_of(ins[14:12], eq, lt);
      step(rb(), eq, lt, mk(3'd2, 0, 0, 0, 1, tk, ctl, 0, 2'd0, 0, 2'd0));
      model_ret++;
      return;
    end
    step(rb(), rb(), rb(), mk(3'd2, 0, 0, 0, 0, 0, ctl, 0, 2'd0, 0, 2'd0));
    if (cls == C_LOAD || cls == C_STORE) begin
      if (abort_mem) begin do_reset(2); return; end
      for (int w = 0; w < mw && w < TO; w++)
        step(1'b0, rb(), rb(), mk(3'd3, 1, st, 0, 0, 0, ctl, 0, 2'd0, 0, 2'd0));
      if (mw >= TO) begin trap_then_reset(2'd2); return; end
      step(1'b1, rb(), rb(), mk(3'd3, 1, st, 0, st, 0, ctl, 0, 2'd0, 0, 2'd0));
      if (st) begin model_ret++; return; end
    end
    if (cls == C_LOAD)
      step(rb(), rb(), rb(), mk(3'd4, 0, 0, 0, 1, 0, ctl, 1, 2'd0, 0, 2'd0));
    else if (cls == C_JAL || cls == C_JALR)
      step(rb(), rb(), rb(), mk(3'd4, 0, 0, 0, 1, 1, ctl, 1, 2'd2, 0, 2'd0));
    else
      step(rb(), rb(), rb(), mk(3'd4, 0, 0, 0, 1, 0, ctl, 1, 2'd1, 0, 2'd0));
    model_ret++;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [OBS_W-1:0] e, a, care;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, mem_req, MemRW, IRWrite, PCWrite, PCSel, ImmSel, BrUn, ASel, BSel,
           ALUSel, RegWEn, WBSel, trap, trap_cause, instret};
      care = (e[55:53] <= 3'd1) ? ~CTL_MASK : '1;
      checks++;
      if ((a & care) !== (e & care)) begin
        errors++;
        $display("FAIL %s cycle_vec @%0t: got=%h expected=%h (care=%h)", tname, $time, a, e, care);
      end
    end
  end

  initial begin
    int cls, fw, mw;
    rst_n = 1'b0; instr = '0; BrEq = 0; BrLT = 0; mem_ready = 0;
    model_ret = '0;
    tname = "reset";
    @(posedge clk); #1;
    do_reset(3);

    tname = "add";   run_instr(32'h002081B3, 0, 0, 0, 0, 0);
    tname = "beq_t"; run_instr(32'h00208463, 0, 0, 1, 0, 0);
    tname = "beq_n"; run_instr(32'h00208463, 0, 0, 0, 1, 0);
    tname = "lw_w3"; run_instr(32'h0000A183, 0, 3, 0, 0, 0);
    tname = "sw";    run_instr(32'h0020A023, 0, 0, 0, 0, 0);
    tname = "jal";   run_instr(32'h008000EF, 0, 0, 0, 0, 0);
    tname = "srai";  run_instr(32'h4040D193, 0, 0, 0, 0, 0);
    tname = "lui";   run_instr(32'h123451B7, 0, 0, 0, 0, 0);
    tname = "fetch_ready_at_limit"; run_instr(32'h002081B3, TO - 1, 0, 0, 0, 0);
    tname = "mem_ready_at_limit";   run_instr(32'h0000A183, 0, TO - 1, 0, 0, 0);

    tname = "random";
    for (int n = 0; n < 200; n++) begin
      cls = $urandom_range(0, 8);
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO - 1) : 0;
      mw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO - 1) : 0;
      run_instr(rand_instr(cls), fw, mw, rb(), rb(), 0);
    end

    tname = "illegal_7f";    run_instr(32'h0000007F, 0, 0, 0, 0, 0);
    tname = "illegal_rand";  run_instr(rand_instr(C_ILL), 1, 0, 0, 0, 0);
    tname = "fetch_timeout"; run_instr(32'h002081B3, TO, 0, 0, 0, 0);
    tname = "mem_timeout";   run_instr(32'h0000A183, 0, TO, 0, 0, 0);
    tname = "pre_abort";     run_instr(32'h002081B3, 0, 0, 0, 0, 0);
    tname = "abort_store";   run_instr(32'h0020A023, 0, 0, 0, 0, 1);
    tname = "after_abort";   run_instr(32'h002081B3, 0, 0, 0, 0, 0);

    // drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
